// File: rtl/fighter_anim_pkg.sv
// Shared types and screen constants for the fighter animation sequencer.
// Optional feature macro: FIGHTER_PUNCH_QUEUE_EN (one-deep punch queue).
package fighter_anim_pkg;

  typedef enum logic {
    ANIM_IDLE  = 1'b0,
    ANIM_PUNCH = 1'b1
  } anim_state_t;

  localparam int HITBOX_W_DEF = 80;
  localparam int HITBOX_H_DEF = 160;
  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;

endpackage

// File: rtl/hitbox_mapper.sv
// Registered compare/subtract stage turning scan coordinates into
// hitbox-local coordinates, clipped to the visible screen.
module hitbox_mapper
  import fighter_anim_pkg::*;
#(
  parameter int HITBOX_W = HITBOX_W_DEF,
  parameter int HITBOX_H = HITBOX_H_DEF
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  output logic       in_box,
  output logic [6:0] local_x,
  output logic [7:0] local_y
);

  logic [10:0] x_w, y_w, px_w, py_w, x_end, y_end;
  logic        in_x, in_y;
  logic        in_box_d, in_box_q;
  logic [6:0]  local_x_d, local_x_q;
  logic [7:0]  local_y_d, local_y_q;

  // Widened to 11 bits so px+W never wraps near the right/bottom edge.
  assign x_w   = {1'b0, DrawX};
  assign y_w   = {1'b0, DrawY};
  assign px_w  = {1'b0, px};
  assign py_w  = {1'b0, py};
  assign x_end = px_w + 11'(HITBOX_W);
  assign y_end = py_w + 11'(HITBOX_H);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    in_x      = (x_w >= px_w) && (x_w < x_end) && (x_w < 11'(H_ACTIVE));
    in_y      = (y_w >= py_w) && (y_w < y_end) && (y_w < 11'(V_ACTIVE));
    in_box_d  = blank & in_x & in_y;
    local_x_d = '0;
    local_y_d = '0;
    if (in_box_d) begin
      local_x_d = 7'(DrawX - px);
      local_y_d = 8'(DrawY - py);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      in_box_q  <= 1'b0;
      local_x_q <= '0;
      local_y_q <= '0;
    end else begin
      in_box_q  <= in_box_d;
      local_x_q <= local_x_d;
      local_y_q <= local_y_d;
    end
  end

  assign in_box  = in_box_q;
  assign local_x = local_x_q;
  assign local_y = local_y_q;

endmodule

// File: rtl/fighter_anim_seq.sv
// Idle/punch animation sequencer with frame-aligned shadow registers.
// Optional feature macro: FIGHTER_PUNCH_QUEUE_EN (queue one punch during PUNCH).
module fighter_anim_seq
  import fighter_anim_pkg::*;
#(
  parameter int HITBOX_W     = HITBOX_W_DEF,
  parameter int HITBOX_H     = HITBOX_H_DEF,
  parameter int IDLE_FRAMES  = 4,
  parameter int IDLE_HOLD    = 8,
  parameter int PUNCH_FRAMES = 3,
  parameter int PUNCH_HOLD   = 4
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       facing_left,
  input  logic       punch_req,
  output logic       anim_state,
  output logic [1:0] frame_idx,
  output logic       mirror,
  output logic       hit_window,
  output logic [6:0] local_x,
  output logic [7:0] local_y,
  output logic       in_box
);

  localparam logic [3:0] IDLE_HOLD_LAST   = 4'(IDLE_HOLD - 1);
  localparam logic [3:0] PUNCH_HOLD_LAST  = 4'(PUNCH_HOLD - 1);
  localparam logic [1:0] IDLE_FRAME_LAST  = 2'(IDLE_FRAMES - 1);
  localparam logic [1:0] PUNCH_FRAME_LAST = 2'(PUNCH_FRAMES - 1);

  anim_state_t state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  hold_q, hold_d;
  logic        armed_q, armed_d;
  logic [9:0]  px_q, px_d, py_q, py_d;
  logic        facing_q, facing_d;
`ifdef FIGHTER_PUNCH_QUEUE_EN
  logic        queued_q, queued_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    armed_d  = armed_q;
`ifdef FIGHTER_PUNCH_QUEUE_EN
    queued_d = queued_q;
`endif
    // Shadow copies only move at vertical blank so a frame never tears.
    px_d     = frame_start ? pos_x       : px_q;
    py_d     = frame_start ? pos_y       : py_q;
    facing_d = frame_start ? facing_left : facing_q;

    unique case (state_q)
      ANIM_IDLE: begin
        if (frame_start) begin
          if (armed_q | punch_req) begin
            state_d = ANIM_PUNCH;
            idx_d   = '0;
            hold_d  = '0;
            armed_d = 1'b0;
          end else if (hold_q == IDLE_HOLD_LAST) begin
            hold_d = '0;
            idx_d  = (idx_q == IDLE_FRAME_LAST) ? 2'd0 : idx_q + 2'd1;
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end else if (punch_req) begin
          armed_d = 1'b1;
        end
      end
      ANIM_PUNCH: begin
`ifdef FIGHTER_PUNCH_QUEUE_EN
        if (punch_req) queued_d = 1'b1;
`endif
        if (frame_start) begin
          if (hold_q == PUNCH_HOLD_LAST) begin
            hold_d = '0;
            if (idx_q == PUNCH_FRAME_LAST) begin
              idx_d   = '0;
`ifdef FIGHTER_PUNCH_QUEUE_EN
              if (queued_q | punch_req) begin
                state_d  = ANIM_PUNCH;
                queued_d = 1'b0;
              end else begin
                state_d = ANIM_IDLE;
              end
`else
              state_d = ANIM_IDLE;
`endif
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
      end
      default: state_d = ANIM_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q  <= ANIM_IDLE;
      idx_q    <= '0;
      hold_q   <= '0;
      armed_q  <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      facing_q <= 1'b0;
`ifdef FIGHTER_PUNCH_QUEUE_EN
      queued_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      armed_q  <= armed_d;
      px_q     <= px_d;
      py_q     <= py_d;
      facing_q <= facing_d;
`ifdef FIGHTER_PUNCH_QUEUE_EN
      queued_q <= queued_d;
`endif
    end
  end

  assign anim_state = state_q;
  assign frame_idx  = idx_q;
  assign mirror     = facing_q;
  assign hit_window = (state_q == ANIM_PUNCH) && (idx_q == 2'd1);

  hitbox_mapper #(
    .HITBOX_W(HITBOX_W),
    .HITBOX_H(HITBOX_H)
  ) u_mapper (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .px      (px_q),
    .py      (py_q),
    .DrawX   (DrawX),
    .DrawY   (DrawY),
    .blank   (blank),
    .in_box  (in_box),
    .local_x (local_x),
    .local_y (local_y)
  );

endmodule

// File: tb/tb_fighter_anim_seq.sv
// Directed self-checking bench for fighter_anim_seq.
// Follows FIGHTER_PUNCH_QUEUE_EN to pick the expected queued-punch behaviour.
module tb_fighter_anim_seq;

  logic       vga_clk = 1'b0;
  logic       Reset, frame_start, blank, facing_left, punch_req;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic       anim_state, mirror, hit_window, in_box;
  logic [1:0] frame_idx;
  logic [6:0] local_x;
  logic [7:0] local_y;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 vga_clk = ~vga_clk;

  fighter_anim_seq dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .facing_left (facing_left),
    .punch_req   (punch_req),
    .anim_state  (anim_state),
    .frame_idx   (frame_idx),
    .mirror      (mirror),
    .hit_window  (hit_window),
    .local_x     (local_x),
    .local_y     (local_y),
    .in_box      (in_box)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  // Checks one punch sequence, pulse k counted after the entry edge.
  task automatic punch_pulse_check(input int k, input int base);
    int  kk;
    logic exp_hit, exp_state;
    logic [1:0] exp_idx;
    kk        = k - base;
    exp_hit   = (kk >= 4) && (kk <= 7);
    exp_state = (kk < 12);
    exp_idx   = (kk < 12) ? 2'(kk / 4) : 2'd0;
    check($sformatf("punch_state_p%0d", k), 32'(anim_state), 32'(exp_state));
    check($sformatf("punch_idx_p%0d", k),   32'(frame_idx),  32'(exp_idx));
    check($sformatf("punch_hit_p%0d", k),   32'(hit_window), 32'(exp_hit));
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; blank = 1'b0; facing_left = 1'b0;
    punch_req = 1'b0; DrawX = '0; DrawY = '0; pos_x = '0; pos_y = '0;
    tick(); tick();
    check("rst_state",  32'(anim_state), 32'd0);
    check("rst_idx",    32'(frame_idx),  32'd0);
    check("rst_mirror", 32'(mirror),     32'd0);
    check("rst_hit",    32'(hit_window), 32'd0);
    check("rst_inbox",  32'(in_box),     32'd0);
    check("rst_lx",     32'(local_x),    32'd0);
    check("rst_ly",     32'(local_y),    32'd0);
    Reset = 1'b0;
    tick();

    // Idle loop: 8 pulses per frame, 4 frames.
    for (int p = 1; p <= 32; p++) begin
      frame_pulse();
      check($sformatf("idle_state_p%0d", p), 32'(anim_state), 32'd0);
      if (p == 7)  check("idle_idx_p7",  32'(frame_idx), 32'd0);
      if (p == 8)  check("idle_idx_p8",  32'(frame_idx), 32'd1);
      if (p == 16) check("idle_idx_p16", 32'(frame_idx), 32'd2);
      if (p == 24) check("idle_idx_p24", 32'(frame_idx), 32'd3);
      if (p == 32) check("idle_idx_p32", 32'(frame_idx), 32'd0);
    end

    // Armed punch: request mid-frame, starts on next frame_start.
    punch_req = 1'b1; tick(); punch_req = 1'b0; tick();
    check("armed_still_idle", 32'(anim_state), 32'd0);
    frame_pulse();
    check("punch_enter_state", 32'(anim_state), 32'd1);
    check("punch_enter_idx",   32'(frame_idx),  32'd0);
    check("punch_enter_hit",   32'(hit_window), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      frame_pulse();
      punch_pulse_check(k, 0);
    end
    frame_pulse();
    check("after_punch_idle", 32'(anim_state), 32'd0);

    // Coincident request and frame_start, then a request at punch pulse 3.
    punch_req = 1'b1; frame_start = 1'b1; tick();
    punch_req = 1'b0; frame_start = 1'b0; tick();
    check("coinc_state", 32'(anim_state), 32'd1);
    check("coinc_idx",   32'(frame_idx),  32'd0);
    for (int k = 1; k <= 3; k++) frame_pulse();
    punch_req = 1'b1; tick(); punch_req = 1'b0; tick();
    for (int k = 4; k <= 11; k++) begin
      frame_pulse();
      punch_pulse_check(k, 0);
    end
    frame_pulse();
`ifdef FIGHTER_PUNCH_QUEUE_EN
    check("queue_p12_state", 32'(anim_state), 32'd1);
    check("queue_p12_idx",   32'(frame_idx),  32'd0);
    for (int k = 13; k <= 24; k++) begin
      frame_pulse();
      punch_pulse_check(k, 12);
    end
`else
    check("noqueue_p12_state", 32'(anim_state), 32'd0);
    check("noqueue_p12_idx",   32'(frame_idx),  32'd0);
    frame_pulse();
    check("noqueue_p13_state", 32'(anim_state), 32'd0);
`endif

    // Mapping clip with box at (600,100), captured as a punch starts.
    pos_x = 10'd600; pos_y = 10'd100;
    punch_req = 1'b1; frame_start = 1'b1; tick();
    punch_req = 1'b0; frame_start = 1'b0;
    DrawX = 10'd639; DrawY = 10'd259; blank = 1'b1;
    tick();
    check("map_corner_inbox", 32'(in_box),  32'd1);
    check("map_corner_lx",    32'(local_x), 32'd39);
    check("map_corner_ly",    32'(local_y), 32'd159);
    DrawX = 10'd599; tick();
    check("map_left_inbox", 32'(in_box),  32'd0);
    check("map_left_lx",    32'(local_x), 32'd0);
    DrawX = 10'd639; DrawY = 10'd260; tick();
    check("map_below_inbox", 32'(in_box),  32'd0);
    check("map_below_ly",    32'(local_y), 32'd0);
    DrawY = 10'd259; blank = 1'b0; tick();
    check("map_blank_inbox", 32'(in_box), 32'd0);
    blank = 1'b1; tick();
    check("map_unblank_inbox", 32'(in_box), 32'd1);

    // Reset mid-punch.
    frame_pulse(); frame_pulse();
    check("pre_rst_state", 32'(anim_state), 32'd1);
    Reset = 1'b1; tick(); tick();
    check("midrst_state", 32'(anim_state), 32'd0);
    check("midrst_idx",   32'(frame_idx),  32'd0);
    check("midrst_inbox", 32'(in_box),     32'd0);
    check("midrst_lx",    32'(local_x),    32'd0);
    Reset = 1'b0; tick();
    check("postrst_inbox", 32'(in_box), 32'd0);

    // Shadow capture: mid-frame changes wait for the next frame_start.
    frame_pulse();
    check("shadow_base_inbox", 32'(in_box), 32'd1);
    facing_left = 1'b1; pos_x = 10'd0;
    tick(); tick();
    check("shadow_hold_mirror", 32'(mirror),  32'd0);
    check("shadow_hold_inbox",  32'(in_box),  32'd1);
    check("shadow_hold_lx",     32'(local_x), 32'd39);
    frame_start = 1'b1; tick();
    frame_start = 1'b0;
    check("shadow_cap_mirror", 32'(mirror), 32'd1);
    check("shadow_cap_inbox",  32'(in_box), 32'd1);
    tick();
    check("shadow_new_inbox", 32'(in_box), 32'd0);
    DrawX = 10'd10; tick();
    check("shadow_new_lx",    32'(local_x), 32'd10);
    check("shadow_new_ly",    32'(local_y), 32'd159);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
